// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
//   NOP_INSTR        - canonical RV32I NOP (addi x0, x0, 0)
//   D_WIDTH_DEFAULT  - width of instruction, PC and PC+4 fields
//   fetch_entry_t    - one queued fetch: instruction with its PC and PC+4
package rv_pipe_pkg;

  localparam int D_WIDTH_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [D_WIDTH_DEFAULT-1:0] instr;
    logic [D_WIDTH_DEFAULT-1:0] pc;
    logic [D_WIDTH_DEFAULT-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage array for the fetch queue: DEPTH entries, synchronous write,
// asynchronous read.
//   i_clk    - write clock
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - entry to store
//   i_raddr  - read index
//   o_rdata  - entry at i_raddr (combinational)
module fetch_queue_ram
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fetch_entry_t  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fetch_entry_t  o_rdata
);

  fetch_entry_t r_mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and occupancy count, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: small FIFO between the PC/fetch stage and decode, replacing
// the IF/ID register. Applies back-pressure to the PC register when full
// and discards everything in flight on a redirect.
//   CLK          - clock, rising edge
//   rst          - asynchronous active-low reset
//   FetchValid   - fetch stage offers {InstrF, PCF, PCPlus4F}
//   FetchReady   - queue accepts an offer this cycle (state-only, no
//                  dependence on DecodeReady)
//   Flush        - redirect from execute; kills queued and offered entries
//   DecodeReady  - decode consumes the head entry
//   ValidD       - head entry valid; InstrD/PCD/PCPlus4D carry it, else
//                  NOP/0/0
//   Count        - current occupancy
module fetch_queue
  import rv_pipe_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEFAULT,
  parameter int DEPTH   = 2
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       FetchValid,
  input  logic [D_WIDTH-1:0]         InstrF,
  input  logic [D_WIDTH-1:0]         PCF,
  input  logic [D_WIDTH-1:0]         PCPlus4F,
  output logic                       FetchReady,
  input  logic                       Flush,
  input  logic                       DecodeReady,
  output logic                       ValidD,
  output logic [D_WIDTH-1:0]         InstrD,
  output logic [D_WIDTH-1:0]         PCD,
  output logic [D_WIDTH-1:0]         PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end
    if (D_WIDTH != D_WIDTH_DEFAULT) begin : g_bad_width
      $error("fetch_queue: D_WIDTH must match fetch_entry_t field width");
    end
  endgenerate

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  assign w_empty    = (r_count == '0);
  assign FetchReady = (r_count != CW'(DEPTH));
  assign ValidD     = !w_empty;
  assign Count      = r_count;

  assign w_push = FetchValid & FetchReady & ~Flush;
  assign w_pop  = ValidD & DecodeReady & ~Flush;

  assign w_wdata = '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F};

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (Flush) begin
      // Redirect: drop everything by collapsing read onto write.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits, so increments wrap modulo DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    InstrD   = D_WIDTH'(NOP_INSTR);
    PCD      = '0;
    PCPlus4D = '0;
    if (!w_empty) begin
      InstrD   = w_head.instr;
      PCD      = w_head.pc;
      PCPlus4D = w_head.pc_plus4;
    end
  end

  a_count_max: assert property (@(posedge CLK) disable iff (!rst)
    r_count <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!rst)
    w_pop |-> (r_count != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model is
// compared against the DUT every falling edge, plus directed literal checks.
module tb_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          CLK = 1'b0;
  logic          rst;
  logic          FetchValid;
  logic [DW-1:0] InstrF;
  logic [DW-1:0] PCF;
  logic [DW-1:0] PCPlus4F;
  logic          FetchReady;
  logic          Flush;
  logic          DecodeReady;
  logic          ValidD;
  logic [DW-1:0] InstrD;
  logic [DW-1:0] PCD;
  logic [DW-1:0] PCPlus4D;
  logic [1:0]    Count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .FetchValid  (FetchValid),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .FetchReady  (FetchReady),
    .Flush       (Flush),
    .DecodeReady (DecodeReady),
    .ValidD      (ValidD),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .Count       (Count)
  );

  always #5 CLK = ~CLK;

  // Reference model: an ordered list of queued entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t mq[$];

  always @(posedge CLK or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit acc;
      bit take;
      acc  = FetchValid && (mq.size() != DEPTH) && !Flush;
      take = (mq.size() != 0) && DecodeReady && !Flush;
      if (Flush) begin
        mq.delete();
      end else begin
        if (take) void'(mq.pop_front());
        if (acc)  mq.push_back('{instr: InstrF, pc: PCF, pc4: PCPlus4F});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    FetchValid = 1'b1;
    PCF        = pc;
    InstrF     = instr;
    PCPlus4F   = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b0; FetchValid = 1'b0; InstrF = '0; PCF = '0; PCPlus4F = '0;
    Flush = 1'b0; DecodeReady = 1'b0;

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge CLK);
        if (mq.size() == 0) begin
          check("cmp_valid", {31'd0, ValidD}, 32'd0);
          check("cmp_instr", InstrD, NOP);
          check("cmp_pc",    PCD, 32'd0);
          check("cmp_pc4",   PCPlus4D, 32'd0);
        end else begin
          check("cmp_valid", {31'd0, ValidD}, 32'd1);
          check("cmp_instr", InstrD, mq[0].instr);
          check("cmp_pc",    PCD, mq[0].pc);
          check("cmp_pc4",   PCPlus4D, mq[0].pc4);
        end
        check("cmp_count", {30'd0, Count}, mq.size());
        check("cmp_ready", {31'd0, FetchReady}, {31'd0, mq.size() != DEPTH});
      end
    join_none

    // 1. Reset then idle
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", {31'd0, ValidD}, 32'd0);
    check("rst_instr", InstrD, 32'h13);
    check("rst_count", {30'd0, Count}, 32'd0);
    check("rst_ready", {31'd0, FetchReady}, 32'd1);
    rst = 1'b1;
    step(); step();
    check("idle_valid", {31'd0, ValidD}, 32'd0);
    check("idle_pc", PCD, 32'd0);

    // 2. Streaming
    DecodeReady = 1'b1;
    offer(32'h0, 32'hA); step();
    check("str_valid", {31'd0, ValidD}, 32'd1);
    check("str_pc0", PCD, 32'h0);
    check("str_pc4_0", PCPlus4D, 32'h4);
    check("str_instr0", InstrD, 32'hA);
    offer(32'h4, 32'hB); step();
    check("str_pc1", PCD, 32'h4);
    check("str_cnt1", {30'd0, Count}, 32'd1);
    offer(32'h8, 32'hC); step();
    check("str_pc2", PCD, 32'h8);
    check("str_pc4_2", PCPlus4D, 32'hC);
    FetchValid = 1'b0; step();
    check("str_drained", {31'd0, ValidD}, 32'd0);

    // 3. Back-pressure
    DecodeReady = 1'b0;
    offer(32'h100, 32'h1100); step();
    offer(32'h104, 32'h1104); step();
    check("bp_count", {30'd0, Count}, 32'd2);
    check("bp_ready", {31'd0, FetchReady}, 32'd0);
    offer(32'h108, 32'h1108); step(); step();
    check("bp_hold_cnt", {30'd0, Count}, 32'd2);
    check("bp_head", PCD, 32'h100);
    DecodeReady = 1'b1; step();
    check("bp_out1", PCD, 32'h104);
    step();
    check("bp_out2", PCD, 32'h108);
    check("bp_out2_i", InstrD, 32'h1108);
    FetchValid = 1'b0; step();
    check("bp_empty", {30'd0, Count}, 32'd0);

    // 4. Pointer wrap: fill to full then drain, five rounds
    for (int r = 0; r < 5; r++) begin
      logic [31:0] base;
      base = 32'h1000 + 32'(r) * 32'h10;
      DecodeReady = 1'b0;
      offer(base, 32'hF000 + 32'(r)); step();
      offer(base + 32'd4, 32'hF100 + 32'(r)); step();
      FetchValid = 1'b0;
      check("wrap_full", {30'd0, Count}, 32'd2);
      DecodeReady = 1'b1;
      check("wrap_pc_a", PCD, base);
      step();
      check("wrap_pc_b", PCD, base + 32'd4);
      step();
      check("wrap_cnt0", {30'd0, Count}, 32'd0);
    end

    // 5. Flush with simultaneous offer and decode-ready while full
    DecodeReady = 1'b0;
    offer(32'h200, 32'h2200); step();
    offer(32'h204, 32'h2204); step();
    check("fl_full", {30'd0, Count}, 32'd2);
    offer(32'h208, 32'h2208);
    DecodeReady = 1'b1; Flush = 1'b1; step();
    Flush = 1'b0; FetchValid = 1'b0; DecodeReady = 1'b0;
    check("fl_valid", {31'd0, ValidD}, 32'd0);
    check("fl_count", {30'd0, Count}, 32'd0);
    check("fl_ready", {31'd0, FetchReady}, 32'd1);
    offer(32'h40, 32'h4040); step();
    FetchValid = 1'b0;
    check("fl_next_pc", PCD, 32'h40);
    check("fl_next_v", {31'd0, ValidD}, 32'd1);
    DecodeReady = 1'b1; step();
    DecodeReady = 1'b0;

    // 6. Asynchronous reset mid-stream
    offer(32'h300, 32'h3300); step();
    offer(32'h304, 32'h3304); step();
    FetchValid = 1'b0;
    check("ar_full", {30'd0, Count}, 32'd2);
    #1 rst = 1'b0;
    #1;
    check("ar_valid", {31'd0, ValidD}, 32'd0);
    check("ar_count", {30'd0, Count}, 32'd0);
    check("ar_instr", InstrD, 32'h13);
    check("ar_ready", {31'd0, FetchReady}, 32'd1);
    step();
    rst = 1'b1;
    DecodeReady = 1'b1;
    step();
    check("ar_no_stale", {31'd0, ValidD}, 32'd0);
    DecodeReady = 1'b0;
    offer(32'h50, 32'h5050); step();
    FetchValid = 1'b0;
    check("ar_new_pc", PCD, 32'h50);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
